// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: operand forwarding mux, funct3 compare, branch-hazard
// stall FSM (IDLE/WAIT), redirect/flush generation and 32-bit performance counters.
module branch_resolve_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_Branch,
    input  logic [2:0]  id_funct3,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_imm,
    input  logic [4:0]  ifidreg_readRegister1,
    input  logic [4:0]  ifidreg_readRegister2,
    input  logic [31:0] id_readData1,
    input  logic [31:0] id_readData2,
    input  logic [1:0]  BForwardA,
    input  logic [1:0]  BForwardB,
    input  logic [31:0] exmem_aluResult,
    input  logic [31:0] memwb_writeData,
    input  logic        idexreg_RegWrite,
    input  logic        idexreg_MemRead,
    input  logic [4:0]  idexreg_writeRegister,
    input  logic        exmemreg_MemRead,
    input  logic [4:0]  exmemreg_writeRegister,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_bubble,
    output logic        branch_taken,
    output logic        ifid_flush,
    output logic [31:0] branch_target,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count,
    output logic [31:0] stall_cycles
);

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} stateT;

    stateT             stateQ, stateD;
    logic              cntQ, cntD;
    logic [1:0]        stallNeed;
    logic              idexHit, exmemHit;
    logic [DATA_W-1:0] opA, opB;
    logic              condMet;
    logic              stallAll, resolveNow, takenNow;

    // 2'b11 is not a legal forward select and falls back to the register file.
    function automatic logic [DATA_W-1:0] selOperand(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rfData,
        input logic [DATA_W-1:0] exData,
        input logic [DATA_W-1:0] wbData
    );
        case (sel)
            2'b10:   return exData;
            2'b01:   return wbData;
            default: return rfData;
        endcase
    endfunction

    function automatic logic branchCond(
        input logic [2:0]        funct3,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        sa = signed'(a);
        sb = signed'(b);
        case (funct3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // x0 is hardwired, so a zero destination can never create a dependency.
    function automatic logic destHits(
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2
    );
        return (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

    assign opA           = selOperand(BForwardA, id_readData1, exmem_aluResult, memwb_writeData);
    assign opB           = selOperand(BForwardB, id_readData2, exmem_aluResult, memwb_writeData);
    assign condMet       = branchCond(id_funct3, opA, opB);
    assign branch_target = id_pc + id_imm;

    assign idexHit  = destHits(idexreg_writeRegister, ifidreg_readRegister1, ifidreg_readRegister2);
    assign exmemHit = destHits(exmemreg_writeRegister, ifidreg_readRegister1, ifidreg_readRegister2);

    // Load in ID/EX needs two cycles before MEM/WB can forward; ALU result or load in EX/MEM needs one.
    always_comb begin
        stallNeed = 2'd0;
        if (id_Branch && (stateQ == IDLE)) begin
            if (idexHit && idexreg_MemRead)
                stallNeed = 2'd2;
            else if (idexHit && idexreg_RegWrite)
                stallNeed = 2'd1;
            else if (exmemHit && exmemreg_MemRead)
                stallNeed = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
            cntQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        case (stateQ)
            IDLE: begin
                if (stallNeed == 2'd2) begin
                    stateD = WAIT;
                    cntD   = 1'b1;
                end
            end
            WAIT: begin
                if (cntQ) begin
                    stateD = IDLE;
                    cntD   = 1'b0;
                end
            end
            default: begin
                stateD = IDLE;
                cntD   = 1'b0;
            end
        endcase
    end

    // Reset forces every control output low, abandoning any in-flight stall sequence.
    always_comb begin
        stallAll   = 1'b0;
        resolveNow = 1'b0;
        takenNow   = 1'b0;
        if (!rst) begin
            case (stateQ)
                IDLE: begin
                    if (stallNeed != 2'd0) begin
                        stallAll = 1'b1;
                    end else if (id_Branch) begin
                        resolveNow = 1'b1;
                        takenNow   = condMet;
                    end
                end
                WAIT:    stallAll = 1'b1;
                default: stallAll = 1'b0;
            endcase
        end
    end

    assign pc_stall     = stallAll;
    assign ifid_stall   = stallAll;
    assign idex_bubble  = stallAll;
    assign branch_taken = takenNow;
    assign ifid_flush   = takenNow;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count <= '0;
            taken_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (resolveNow) branch_count <= branch_count + 32'd1;
            if (takenNow)   taken_count  <= taken_count + 32'd1;
            if (stallAll)   stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: expectations are queued per step and
// drained against the DUT outputs mid-cycle; counters follow a small bench model.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        id_Branch;
    logic [2:0]  id_funct3;
    logic [31:0] id_pc, id_imm;
    logic [4:0]  ifidreg_readRegister1, ifidreg_readRegister2;
    logic [31:0] id_readData1, id_readData2;
    logic [1:0]  BForwardA, BForwardB;
    logic [31:0] exmem_aluResult, memwb_writeData;
    logic        idexreg_RegWrite, idexreg_MemRead;
    logic [4:0]  idexreg_writeRegister;
    logic        exmemreg_MemRead;
    logic [4:0]  exmemreg_writeRegister;
    logic        pc_stall, ifid_stall, idex_bubble, branch_taken, ifid_flush;
    logic [31:0] branch_target, branch_count, taken_count, stall_cycles;

    int checkCount = 0;
    int errCount   = 0;

    string       expTag[$];
    logic [31:0] expVal[$];

    logic [31:0] mBranch, mTaken, mStall;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .id_Branch(id_Branch), .id_funct3(id_funct3),
        .id_pc(id_pc), .id_imm(id_imm),
        .ifidreg_readRegister1(ifidreg_readRegister1), .ifidreg_readRegister2(ifidreg_readRegister2),
        .id_readData1(id_readData1), .id_readData2(id_readData2),
        .BForwardA(BForwardA), .BForwardB(BForwardB),
        .exmem_aluResult(exmem_aluResult), .memwb_writeData(memwb_writeData),
        .idexreg_RegWrite(idexreg_RegWrite), .idexreg_MemRead(idexreg_MemRead),
        .idexreg_writeRegister(idexreg_writeRegister),
        .exmemreg_MemRead(exmemreg_MemRead), .exmemreg_writeRegister(exmemreg_writeRegister),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
        .branch_taken(branch_taken), .ifid_flush(ifid_flush), .branch_target(branch_target),
        .branch_count(branch_count), .taken_count(taken_count), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL timeout checks=%0d", checkCount);
        $fatal(1, "bench did not finish");
    end

    function automatic logic [31:0] observe(input string tag);
        if (tag == "pc_stall")      return {31'd0, pc_stall};
        if (tag == "ifid_stall")    return {31'd0, ifid_stall};
        if (tag == "idex_bubble")   return {31'd0, idex_bubble};
        if (tag == "branch_taken")  return {31'd0, branch_taken};
        if (tag == "ifid_flush")    return {31'd0, ifid_flush};
        if (tag == "branch_target") return branch_target;
        if (tag == "branch_count")  return branch_count;
        if (tag == "taken_count")   return taken_count;
        if (tag == "stall_cycles")  return stall_cycles;
        return 32'hxxxx_xxxx;
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        expTag.push_back(tag);
        expVal.push_back(v);
    endtask

    task automatic drain(input string step);
        string       tag;
        logic [31:0] exp, obs;
        while (expTag.size() > 0) begin
            tag = expTag.pop_front();
            exp = expVal.pop_front();
            obs = observe(tag);
            checkCount++;
            assert (obs === exp) else begin
                errCount++;
                $error("FAIL %s/%s observed=%h expected=%h", step, tag, obs, exp);
            end
        end
    endtask

    task automatic clearIn();
        id_Branch = 0; id_funct3 = 3'b000; id_pc = 32'h0; id_imm = 32'h0;
        ifidreg_readRegister1 = 0; ifidreg_readRegister2 = 0;
        id_readData1 = 0; id_readData2 = 0; BForwardA = 2'b00; BForwardB = 2'b00;
        exmem_aluResult = 0; memwb_writeData = 0;
        idexreg_RegWrite = 0; idexreg_MemRead = 0; idexreg_writeRegister = 0;
        exmemreg_MemRead = 0; exmemreg_writeRegister = 0;
    endtask

    // Queue this cycle's expectations, compare mid-cycle, then advance the counter model past the edge.
    task automatic checkStep(input string step, input bit stall, input bit res, input bit tk);
        push("pc_stall", {31'd0, stall});
        push("ifid_stall", {31'd0, stall});
        push("idex_bubble", {31'd0, stall});
        push("branch_taken", {31'd0, tk});
        push("ifid_flush", {31'd0, tk});
        push("branch_target", id_pc + id_imm);
        push("branch_count", mBranch);
        push("taken_count", mTaken);
        push("stall_cycles", mStall);
        #2;
        drain(step);
        if (rst) begin
            mBranch = 0; mTaken = 0; mStall = 0;
        end else begin
            mBranch += {31'd0, res};
            mTaken  += {31'd0, tk};
            mStall  += {31'd0, stall};
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        bit          tk;
    } cmpRowT;

    cmpRowT cmpTab[8];

    initial begin
        cmpTab[0] = '{3'b010, 32'd5, 32'd5, 1'b0};
        cmpTab[1] = '{3'b011, 32'd5, 32'd5, 1'b0};
        cmpTab[2] = '{3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0};
        cmpTab[3] = '{3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1};
        cmpTab[4] = '{3'b110, 32'd1, 32'hFFFF_FFFF, 1'b1};
        cmpTab[5] = '{3'b100, 32'd1, 32'hFFFF_FFFF, 1'b0};
        cmpTab[6] = '{3'b000, 32'd1, 32'd2, 1'b0};
        cmpTab[7] = '{3'b001, 32'd1, 32'd1, 1'b0};
        mBranch = 0; mTaken = 0; mStall = 0;

        clearIn();
        rst = 1;

        // Reset with a hazardous branch present: nothing may assert.
        @(negedge clk);
        id_Branch = 1; idexreg_RegWrite = 1; idexreg_writeRegister = 5; ifidreg_readRegister1 = 5;
        checkStep("reset", 0, 0, 0);

        // No hazard, BEQ 5,5.
        @(negedge clk);
        rst = 0; clearIn();
        id_Branch = 1; id_funct3 = 3'b000; id_readData1 = 5; id_readData2 = 5;
        id_pc = 32'h100; id_imm = 32'h20;
        checkStep("beq_nohaz", 0, 1, 1);

        // ALU dependency: one stall, then EX/MEM forward.
        @(negedge clk);
        clearIn();
        id_Branch = 1; id_funct3 = 3'b001; ifidreg_readRegister1 = 5;
        idexreg_RegWrite = 1; idexreg_writeRegister = 5;
        checkStep("alu_stall", 1, 0, 0);
        @(negedge clk);
        clearIn();
        id_Branch = 1; id_funct3 = 3'b001; ifidreg_readRegister1 = 5;
        exmemreg_writeRegister = 5; BForwardA = 2'b10; exmem_aluResult = 7;
        checkStep("alu_fwd", 0, 1, 1);

        // Load dependency: two stalls (second in WAIT with hazards gone), then MEM/WB forward.
        @(negedge clk);
        clearIn();
        id_Branch = 1; id_funct3 = 3'b100; ifidreg_readRegister1 = 6; ifidreg_readRegister2 = 7;
        id_readData2 = 1; idexreg_MemRead = 1; idexreg_RegWrite = 1; idexreg_writeRegister = 6;
        checkStep("load_stall0", 1, 0, 0);
        @(negedge clk);
        clearIn();
        id_Branch = 1; id_funct3 = 3'b100; ifidreg_readRegister1 = 6; ifidreg_readRegister2 = 7;
        id_readData2 = 1;
        checkStep("load_wait", 1, 0, 0);
        @(negedge clk);
        BForwardA = 2'b01; memwb_writeData = 32'hFFFF_FFFF;
        checkStep("load_blt", 0, 1, 1);
        @(negedge clk);
        id_funct3 = 3'b110;
        checkStep("load_bltu", 0, 1, 0);

        // Load in EX/MEM matching rs2: one stall; then 2'b11 on A falls back to the register file.
        @(negedge clk);
        clearIn();
        id_Branch = 1; id_funct3 = 3'b000; ifidreg_readRegister1 = 3; ifidreg_readRegister2 = 9;
        id_readData1 = 4; exmemreg_MemRead = 1; exmemreg_writeRegister = 9;
        checkStep("exmem_load_stall", 1, 0, 0);
        @(negedge clk);
        clearIn();
        id_Branch = 1; id_funct3 = 3'b000; ifidreg_readRegister1 = 3; ifidreg_readRegister2 = 9;
        id_readData1 = 4; BForwardA = 2'b11; exmem_aluResult = 99;
        BForwardB = 2'b01; memwb_writeData = 4;
        checkStep("exmem_load_fwd", 0, 1, 1);

        // Reset asserted in WAIT.
        @(negedge clk);
        clearIn();
        id_Branch = 1; ifidreg_readRegister1 = 6; idexreg_MemRead = 1; idexreg_RegWrite = 1;
        idexreg_writeRegister = 6;
        checkStep("rstwait_enter", 1, 0, 0);
        @(negedge clk);
        clearIn();
        rst = 1; id_Branch = 1;
        checkStep("rstwait_hold", 0, 0, 0);
        @(negedge clk);
        rst = 0;
        id_Branch = 1; id_funct3 = 3'b101; id_readData1 = 3; id_readData2 = 3;
        id_pc = 32'hFFFF_FFF0; id_imm = 32'h20;
        checkStep("rstwait_idle", 0, 1, 1);

        // Compare table, no hazards.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            clearIn();
            id_Branch = 1; id_funct3 = cmpTab[i].f3;
            id_readData1 = cmpTab[i].a; id_readData2 = cmpTab[i].b;
            id_pc = 32'h200 + 32'(i * 4); id_imm = 32'hFFFF_FFF8;
            checkStep("cmp_table", 0, 1, cmpTab[i].tk);
        end

        // x0 destination never stalls.
        @(negedge clk);
        clearIn();
        id_Branch = 1; idexreg_RegWrite = 1; idexreg_MemRead = 1; idexreg_writeRegister = 0;
        exmemreg_MemRead = 1; exmemreg_writeRegister = 0;
        checkStep("x0_dest", 0, 1, 1);

        // Non-branch with a matching load never stalls; following branch is still in IDLE.
        @(negedge clk);
        clearIn();
        ifidreg_readRegister1 = 5; idexreg_MemRead = 1; idexreg_RegWrite = 1; idexreg_writeRegister = 5;
        checkStep("nonbranch", 0, 0, 0);
        @(negedge clk);
        clearIn();
        id_Branch = 1; id_funct3 = 3'b001; id_readData1 = 1; id_readData2 = 2;
        checkStep("after_nonbranch", 0, 1, 1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

ID-stage branch resolution and branch-hazard stall control for the 5-stage RV32I pipeline. It sits directly downstream of the branch forwarding unit and consumes its BForwardA/BForwardB selects to pick branch operands. It stalls the front end while a branch source is still in flight and cannot yet be forwarded. When it resolves the branch it drives the redirect target and IF/ID flush, and it keeps 32-bit performance counters.

## Interface
- No parameters; data width is fixed at 32 bits and register address width at 5 bits.
- clk  in  1  Pipeline clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- id_Branch  in  1  The instruction in ID is a conditional branch.
- id_funct3  in  3  Branch funct3.
- id_pc, id_imm  in  32  PC and sign-extended B-immediate of the ID instruction.
- ifidreg_readRegister1/2  in  5  rs1/rs2 of the ID instruction.
- id_readData1/2  in  32  Register file read data.
- BForwardA/B  in  2  Operand selects from the branch forwarding unit.
- exmem_aluResult  in  32  Forwarding source selected by 2'b10.
- memwb_writeData  in  32  Forwarding source selected by 2'b01.
- idexreg_RegWrite, idexreg_MemRead  in  1  Control bits of the instruction in ID/EX.
- idexreg_writeRegister  in  5  Destination register of the instruction in ID/EX.
- exmemreg_MemRead  in  1  Control bit of the instruction in EX/MEM.
- exmemreg_writeRegister  in  5  Destination register of the instruction in EX/MEM.
- pc_stall, ifid_stall, idex_bubble  out  1  Hold PC, hold IF/ID, insert a NOP into ID/EX.
- branch_taken, ifid_flush  out  1  Redirect the PC to branch_target and squash IF/ID.
- branch_target  out  32  id_pc + id_imm.
- branch_count, taken_count, stall_cycles  out  32  Performance counters.

## Operation
- Operand mux, for A and likewise B:
  - 2'b00 selects id_readData.
  - 2'b10 selects exmem_aluResult.
  - 2'b01 selects memwb_writeData.
  - 2'b11 is treated as 2'b00.
- Compare by funct3:
  - 000 BEQ: equal.
  - 001 BNE: not equal.
  - 100 BLT: signed less-than.
  - 101 BGE: signed greater-or-equal.
  - 110 BLTU: unsigned less-than.
  - 111 BGEU: unsigned greater-or-equal.
  - 010 and 011: never taken.
- Hazard match: the ID/EX or EX/MEM destination is nonzero and equals a used rs. Both rs1 and rs2 are checked.
- Stall need N is evaluated only when id_Branch is high and state is IDLE. The first matching rule wins:
  - ID/EX match with idexreg_MemRead: N=2.
  - ID/EX match with idexreg_RegWrite: N=1.
  - EX/MEM match with exmemreg_MemRead: N=1.
  - Otherwise N=0.
- FSM with states IDLE and WAIT, plus a 1-bit count register cnt.
  - IDLE, N>0: assert pc_stall, ifid_stall and idex_bubble. If N=2, load cnt=1 and go to WAIT; if N=1, stay in IDLE.
  - IDLE, N=0, id_Branch high: the branch resolves this cycle. branch_taken = ifid_flush = compare result.
  - WAIT: assert all three stalls and suppress hazard evaluation. When cnt==1, go to IDLE and clear cnt.
- Total stall cycles equal N, after which the dependency is forwardable:
  - ALU result arrives via EX/MEM as 2'b10.
  - Load data arrives via MEM/WB as 2'b01.
- branch_taken and ifid_flush are 0 whenever a stall is asserted. Stall and flush are never high together.
- branch_target = id_pc + id_imm, modulo 2^32, driven at all times.
- Counters wrap modulo 2^32:
  - branch_count increments once per resolved branch.
  - taken_count increments once per taken branch.
  - stall_cycles increments every cycle in which pc_stall is high.

## Timing
- Stall, flush, taken and target outputs are combinational from the current inputs and state, valid in the same cycle.
- State, cnt and the counters update on the rising clk edge.
- Reset values:
  - State IDLE, cnt 0.
  - All counters 0.
  - With rst high, every stall, taken and flush output is 0.
- Reset in WAIT returns the block to IDLE at the next edge. No stall is asserted while rst is high, and the in-flight stall sequence is abandoned.
- Resolution latency: a branch with N required stalls resolves in cycle N after entering ID (cycle 0 = first ID cycle).
- A non-branch in ID never stalls or flushes, regardless of any register match.
- x0 as a source never causes a stall.

## Test plan
- No hazard: BEQ with id_readData1 = id_readData2 = 5, pc 0x100, imm 0x20, selects 00 → same cycle: branch_taken=1, ifid_flush=1, target 0x120; branch_count=1 and taken_count=1 after the edge.
- ALU dependency: x5 in ID/EX with RegWrite; BNE x5,x0 → 1 stall cycle (pc_stall, ifid_stall, idex_bubble high). The next cycle BForwardA=10 with exmem_aluResult=7 → taken; stall_cycles=1.
- Load dependency: lw x6 in ID/EX with MemRead; BLT x6,x7 → 2 stall cycles with the FSM visiting WAIT. In cycle 2, BForwardA=01 with memwb_writeData=0xFFFFFFFF (-1) against x7=1 → taken. The BLTU equivalent with the same operands → not taken.
- Load in EX/MEM: exmemreg_MemRead with a match on rs2 → exactly 1 stall cycle, then resolve.
- Reset mid-WAIT: assert rst in the WAIT cycle → stalls drop to 0, counters read 0, state IDLE after the edge.
- Guards: funct3=010 with equal operands → not taken, branch_count still increments. A destination equal to x0, or id_Branch=0 with a matching rs → no stall.
